uart_axil_master: RTL and testbench

UART_AXIL_MASTER -- requirements
Module: uart_axil_master

---
 rtl/uart_axil_master.sv | 142 ++++++++++++++
 tb/tb_uart_axil_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_master.sv
// uart_axil_master: bridges a byte-oriented UART command stream ('W'/'R' + address [+ data])
// onto an AXI-Lite master port and returns a status byte (plus read data) over tx.
module uart_axil_master #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] m_axil_awaddr,
    output logic [2:0]  m_axil_awprot,
    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    input  logic [1:0]  m_axil_bresp,
    input  logic        m_axil_bvalid,
    output logic        m_axil_bready,
    output logic [31:0] m_axil_araddr,
    output logic [2:0]  m_axil_arprot,
    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp,
    input  logic        m_axil_rvalid,
    output logic        m_axil_rready,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND} state_t;
    localparam int IW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic          is_rd;
    logic [2:0]    cnt;
    logic [IW-1:0] idle_cnt;
    logic [31:0]   addr, data, shift;

    assign m_axil_awaddr = addr;
    assign m_axil_araddr = addr;
    assign m_axil_wdata  = data;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign m_axil_wstrb  = 4'hF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            is_rd          <= 1'b0;
            cnt            <= '0;
            idle_cnt       <= '0;
            addr           <= '0;
            data           <= '0;
            shift          <= '0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= rx_valid && (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND});
            case (state)
                IDLE: if (rx_valid && (rx_data == 8'h57 || rx_data == 8'h52)) begin
                    is_rd    <= rx_data == 8'h52;
                    cnt      <= '0;
                    idle_cnt <= '0;
                    state    <= ADDR;
                end
                ADDR, DATA: if (rx_valid) begin
                    idle_cnt <= '0;
                    cnt      <= cnt + 3'd1;
                    if (state == ADDR) addr <= {addr[23:0], rx_data};
                    else data <= {data[23:0], rx_data};
                    if (cnt == 3'd3) begin
                        cnt <= '0;
                        if (state == DATA) begin
                            state          <= WR_REQ;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                        end else if (is_rd) begin
                            state          <= RD_REQ;
                            m_axil_arvalid <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    idle_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                // AW and W complete independently; move on once neither is still pending
                WR_REQ: begin
                    if (m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wready) m_axil_wvalid <= 1'b0;
                    if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
                        m_axil_bready <= 1'b1;
                        state         <= WR_RESP;
                    end
                end
                WR_RESP: if (m_axil_bvalid) begin
                    m_axil_bready <= 1'b0;
                    tx_data       <= (m_axil_bresp == 2'b00) ? 8'h4B : 8'h45;
                    tx_valid      <= 1'b1;
                    cnt           <= '0;
                    state         <= SEND;
                end
                RD_REQ: if (m_axil_arready) begin
                    m_axil_arvalid <= 1'b0;
                    m_axil_rready  <= 1'b1;
                    state          <= RD_RESP;
                end
                RD_RESP: if (m_axil_rvalid) begin
                    m_axil_rready <= 1'b0;
                    shift         <= m_axil_rdata;
                    tx_data       <= (m_axil_rresp == 2'b00) ? 8'h4B : 8'h45;
                    tx_valid      <= 1'b1;
                    cnt           <= '0;
                    state         <= SEND;
                end
                SEND: if (tx_ready) begin
                    tx_data <= shift[31:24];
                    shift   <= {shift[23:0], 8'h00};
                    cnt     <= cnt + 3'd1;
                    if (cnt == (is_rd ? 3'd4 : 3'd0)) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_axil_master.sv
// tb_uart_axil_master: directed bench with a small AXI-Lite slave model and a tx byte sink.
module tb_uart_axil_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
    logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_bvalid = 1'b0;
    logic        m_axil_arready = 1'b0, m_axil_rvalid = 1'b0;
    logic [1:0]  m_axil_bresp = 2'b00, m_axil_rresp = 2'b00;
    logic [31:0] m_axil_rdata = 32'h0;
    logic        overrun;

    int vectors = 0, miscompares = 0;
    int aw_delay = 0;
    logic r_hold = 1'b0, tx_ready_en = 1'b1;
    logic [31:0] rd_val = 32'h0;
    logic [1:0] rd_resp = 2'b00;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, aw_wait = 0;
    int aw_hi = 0, w_hi = 0, ovr = 0, unstable = 0;
    logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
    logic [7:0] txq[$];
    logic [7:0] held = 8'h00;
    logic held_ok = 1'b0;

    uart_axil_master #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // slave and sink drive their inputs mid-cycle from what they observed at the last edge
    always @(negedge clk) begin
        m_axil_awready = m_axil_awvalid && aw_wait >= aw_delay;
        m_axil_wready  = m_axil_wvalid;
        m_axil_bvalid  = aw_hs > b_hs && w_hs > b_hs;
        m_axil_bresp   = 2'b00;
        m_axil_arready = m_axil_arvalid;
        m_axil_rvalid  = ar_hs > r_hs && !r_hold;
        m_axil_rdata   = rd_val;
        m_axil_rresp   = rd_resp;
        tx_ready       = tx_ready_en;
    end

    always @(posedge clk) begin
        if (m_axil_awvalid) aw_hi <= aw_hi + 1;
        if (m_axil_wvalid) w_hi <= w_hi + 1;
        if (m_axil_awvalid && m_axil_awready) begin
            aw_hs <= aw_hs + 1;
            cap_awaddr <= m_axil_awaddr;
            aw_wait <= 0;
        end else if (m_axil_awvalid) begin
            aw_wait <= aw_wait + 1;
        end
        if (m_axil_wvalid && m_axil_wready) begin
            w_hs <= w_hs + 1;
            cap_wdata <= m_axil_wdata;
        end
        if (m_axil_bvalid && m_axil_bready) b_hs <= b_hs + 1;
        if (m_axil_arvalid && m_axil_arready) begin
            ar_hs <= ar_hs + 1;
            cap_araddr <= m_axil_araddr;
        end
        if (m_axil_rvalid && m_axil_rready) r_hs <= r_hs + 1;
        if (overrun) ovr <= ovr + 1;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (tx_valid && !tx_ready) begin
            if (held_ok && tx_data != held) unstable <= unstable + 1;
            held <= tx_data;
            held_ok <= 1'b1;
        end else begin
            held_ok <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_tx(input int base, input int n);
        for (int k = 0; k < 200 && txq.size() < base + n; k++) @(negedge clk);
        check("tx_count", txq.size() - base, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_tx(input int base, input int n, input logic [39:0] exp);
        for (int i = 0; i < n; i++)
            check($sformatf("tx_byte%0d", i), (base + i < txq.size()) ? txq[base + i] : 8'hxx, exp[8*(n-1-i) +: 8]);
    endtask

    initial begin
        int base, aw0, w0, b0, ar0, awh0, wh0, ov0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_awvalid", m_axil_awvalid, 0);
        check("rst_wvalid", m_axil_wvalid, 0);
        check("rst_arvalid", m_axil_arvalid, 0);
        check("rst_readies", {m_axil_bready, m_axil_rready, overrun}, 0);
        check("rst_tx_data", tx_data, 0);
        check("tied_prot_strb", {m_axil_awprot, m_axil_arprot, m_axil_wstrb}, 32'h0F);
        reset_n = 1'b1;
        @(negedge clk);

        // junk byte in IDLE is ignored silently
        base = txq.size();
        send_byte(8'h41);
        repeat (4) @(negedge clk);
        check("junk_no_tx", txq.size() - base, 0);
        check("junk_no_ovr", ovr, 0);
        check("junk_idle", 32'(dut.state), 0);

        // basic write
        base = txq.size(); aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        send_byte(8'h57); send_word(32'h4); send_word(32'h1);
        check("wr_lat_aw", m_axil_awvalid, 1);
        check("wr_lat_w", m_axil_wvalid, 1);
        wait_tx(base, 1);
        check("wr_awaddr", cap_awaddr, 32'h4);
        check("wr_wdata", cap_wdata, 32'h1);
        check("wr_aw_hs", aw_hs - aw0, 1);
        check("wr_w_hs", w_hs - w0, 1);
        check("wr_b_hs", b_hs - b0, 1);
        check_tx(base, 1, 40'h4B);

        // read OKAY
        base = txq.size(); rd_val = 32'hDEADBEEF; rd_resp = 2'b00;
        send_byte(8'h52); send_word(32'hC);
        check("rd_lat_ar", m_axil_arvalid, 1);
        wait_tx(base, 5);
        check("rd_araddr", cap_araddr, 32'hC);
        check_tx(base, 5, 40'h4B_DEADBEEF);

        // read SLVERR: data still sent
        base = txq.size(); rd_val = 32'h12345678; rd_resp = 2'b10;
        send_byte(8'h52); send_word(32'h100);
        wait_tx(base, 5);
        check_tx(base, 5, 40'h45_12345678);
        rd_resp = 2'b00;

        // write with awready late, wready immediate
        base = txq.size(); aw_delay = 2; awh0 = aw_hi; wh0 = w_hi; b0 = b_hs;
        send_byte(8'h57); send_word(32'h10); send_word(32'hA5A55A5A);
        wait_tx(base, 1);
        check("dly_aw_hold", aw_hi - awh0, 3);
        check("dly_w_hold", w_hi - wh0, 1);
        check("dly_b_hs", b_hs - b0, 1);
        check("dly_awaddr", cap_awaddr, 32'h10);
        check("dly_wdata", cap_wdata, 32'hA5A55A5A);
        check_tx(base, 1, 40'h4B);
        aw_delay = 0;

        // partial command times out, next command works
        base = txq.size(); ar0 = ar_hs; aw0 = aw_hs;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        repeat (20) @(negedge clk);
        check("to_no_ar", ar_hs - ar0, 0);
        check("to_no_aw", aw_hs - aw0, 0);
        check("to_idle", 32'(dut.state), 0);
        check("to_no_tx", txq.size() - base, 0);
        rd_val = 32'h0BADF00D;
        send_byte(8'h52); send_word(32'h8);
        wait_tx(base, 5);
        check("to_ar_hs", ar_hs - ar0, 1);
        check("to_araddr", cap_araddr, 32'h8);
        check_tx(base, 5, 40'h4B_0BADF00D);

        // tx stall plus rx byte dropped during RD_RESP
        base = txq.size(); ov0 = ovr; r_hold = 1'b1; tx_ready_en = 1'b0; rd_val = 32'hCAFE0123;
        send_byte(8'h52); send_word(32'h20);
        for (int k = 0; k < 50 && !m_axil_rready; k++) @(negedge clk);
        check("ovr_in_rd_resp", m_axil_rready, 1);
        send_byte(8'h99);
        r_hold = 1'b0;
        for (int k = 0; k < 50 && !tx_valid; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, 8'h4B);
        check("stall_no_tx", txq.size() - base, 0);
        tx_ready_en = 1'b1;
        wait_tx(base, 5);
        check_tx(base, 5, 40'h4B_CAFE0123);
        check("stall_stable", unstable, 0);
        check("ovr_once", ovr - ov0, 1);
        check("end_idle", 32'(dut.state), 0);
        check("end_tx_valid", tx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
